tree_plru: RTL
==============

TREE_PLRU -- requirements
Module: tree_plru

Interface
REQ-001 Parameter WAYS, default 4, SHALL set the associativity; a power of two, 2..16.
REQ-002 Parameter SETS, default 64, SHALL set the number of sets; a power of two, at least 2.
REQ-003 Derived IDX_W = clog2(SETS) SHALL set the index width; it is not user-settable.
REQ-004 clk_l1  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_l1  in  1  reset, asynchronous, active-high.
REQ-006 lookup_req  in  1  requests a victim way for lookup_index.
REQ-007 lookup_index  in  IDX_W  set for the victim lookup.
REQ-008 valid  in  WAYS  line-valid bits of the looked-up set, sampled with lookup_req.
REQ-009 lookup_ack  out  1  registered, one-cycle pulse marking replace_way as valid.
REQ-010 replace_way  out  WAYS  registered one-hot victim way.
REQ-011 access_en  in  1  records a hit or fill.
REQ-012 access_index  in  IDX_W  set being accessed.
REQ-013 access_way  in  WAYS  one-hot way being accessed.
REQ-014 flush  in  1  synchronous clear of all replacement state.
REQ-015 err  out  1  registered, one-cycle pulse flagging a malformed access_way.

Function
REQ-016 State SHALL be WAYS-1 tree bits per set, held in flops (not SRAM), heap-ordered with node 1 as the root; node n has children 2n and 2n+1.
REQ-017 Victim walk: start at the root; bit=0 SHALL go to the lower-index half, bit=1 to the upper-index half; the leaf reached is the victim.
REQ-018 Access update: every node on the path to access_way SHALL be written to point away from access_way; nodes off the path SHALL be unchanged.
REQ-019 Invalid-first: if any bit of valid is 0, replace_way SHALL be the highest-index invalid way, and the tree walk is ignored.
REQ-020 Latency: lookup_req at cycle N SHALL give lookup_ack=1 and the new replace_way at cycle N+1.
REQ-021 The lookup SHALL use the tree state at the start of cycle N; an access or flush in cycle N SHALL NOT affect that result.
REQ-022 replace_way SHALL hold its last value while lookup_ack=0.
REQ-023 Back-to-back lookup_req SHALL be accepted every cycle with no stall.
REQ-024 An access_way that is not one-hot (zero or multi-bit) with access_en=1 SHALL leave state unchanged and pulse err in the next cycle.
REQ-025 access_way is ignored when access_en=0, and err SHALL NOT assert.
REQ-026 flush SHALL clear all tree bits of all sets at the clock edge.
REQ-027 flush and access_en in the same cycle: flush SHALL win and the access is dropped.
REQ-028 An access in cycle N SHALL be visible to a lookup in cycle N+1 or later, for the same index.
REQ-029 Accesses to different indices SHALL never disturb other sets.

Reset
REQ-030 rst_l1=1 SHALL immediately clear all tree bits, lookup_ack, replace_way (all zero) and err, independent of clk_l1.
REQ-031 While rst_l1=1, all inputs SHALL be ignored.
REQ-032 After release, the first lookup with all ways valid SHALL return way 0.
REQ-033 Reset asserted with a lookup in flight SHALL cancel it; no lookup_ack is produced.

Verification (WAYS=4, SETS=64)
REQ-034 Reset, then lookup index 5 with valid=0111 -> next cycle lookup_ack=1, replace_way=1000.
REQ-035 After reset, lookup index 5 with valid=1111 -> replace_way=0001.
REQ-036 Access index 5 way 0001, then lookup valid=1111 -> replace_way=0100; then access way 0100 and lookup again -> replace_way=0010; index 6 lookup still returns 0001.
REQ-037 Access with access_way=0011 -> err=1 for one cycle; a subsequent lookup of that index is unchanged (0001).
REQ-038 Accesses on several sets, then flush together with access_en -> every set's lookup (valid=1111) returns 0001.
REQ-039 Assert rst_l1 mid-clock while lookup_ack=1 -> lookup_ack, replace_way and err go to 0 before the next edge, with no pending ack after release.

Source files
------------

// File: rtl/tree_plru_if.sv
// Tree pseudo-LRU replacement port bundle: victim lookup, access update, flush, error.
// Latency: none, this file only groups the signals.
// Backpressure: none; lookups and accesses may be issued every cycle.
//
// Ports (master = cache controller, slave = tree_plru):
//   lookup_req/lookup_index/valid   -> victim request for one set plus its line-valid bits
//   lookup_ack/replace_way          <- registered one-cycle ack and one-hot victim way
//   access_en/access_index/access_way -> hit or fill that updates one set's tree
//   flush                           -> clear all replacement state
//   err                             <- one-cycle pulse for a malformed access_way
interface tree_plru_if #(
  parameter int WAYS = 4,
  parameter int SETS = 64
);
  localparam int IDX_W = $clog2(SETS);

  logic             lookup_req;
  logic [IDX_W-1:0] lookup_index;
  logic [WAYS-1:0]  valid;
  logic             lookup_ack;
  logic [WAYS-1:0]  replace_way;
  logic             access_en;
  logic [IDX_W-1:0] access_index;
  logic [WAYS-1:0]  access_way;
  logic             flush;
  logic             err;

  modport master (
    output lookup_req, lookup_index, valid, access_en, access_index, access_way, flush,
    input  lookup_ack, replace_way, err
  );

  modport slave (
    input  lookup_req, lookup_index, valid, access_en, access_index, access_way, flush,
    output lookup_ack, replace_way, err
  );
endinterface

// File: rtl/tree_plru.sv
// Tree pseudo-LRU victim selector with invalid-first override, one tree per set in flops.
// Latency: lookup_req in cycle N -> lookup_ack/replace_way in cycle N+1; access visible from N+1.
// Backpressure: none; a lookup and an access are accepted every cycle with no stall.
//
// Ports:
//   clk_l1 - single clock, all state updates on its rising edge
//   rst_l1 - asynchronous active-high reset, clears trees and all outputs
//   bus    - tree_plru_if slave modport (lookup, access, flush, err)
//
// Tree layout per set: node n (1..WAYS-1) lives in bit n-1; children of n are 2n and 2n+1,
// leaves WAYS..2*WAYS-1 map to ways 0..WAYS-1. A node bit of 0 points at the lower half.
module tree_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 64
) (
  input  logic         clk_l1,
  input  logic         rst_l1,
  tree_plru_if.slave   bus
);

  localparam int IDX_W = $clog2(SETS);

  logic [WAYS-2:0] r_tree [SETS];
  logic            r_ack;
  logic [WAYS-1:0] r_way;
  logic            r_err;

  logic [WAYS-2:0]   w_look_tree;
  logic [WAYS-2:0]   w_acc_tree;
  logic [WAYS-2:0]   w_acc_next;
  logic [2*WAYS-1:1] w_on;
  logic [2*WAYS-1:1] w_sub;
  logic [WAYS-1:0]   w_inv_sel;
  logic              w_any_inv;
  logic              w_acc_ok;
  logic [IDX_W-1:0]  w_look_idx;
  logic [IDX_W-1:0]  w_acc_idx;

  assign w_look_idx  = bus.lookup_index;
  assign w_acc_idx   = bus.access_index;
  assign w_look_tree = r_tree[w_look_idx];
  assign w_acc_tree  = r_tree[w_acc_idx];
  assign w_acc_ok    = $onehot(bus.access_way);
  assign w_any_inv   = ~&bus.valid;

  // Victim walk: w_on marks the nodes on the path selected by the current tree bits.
  // The leaf bits of w_on form the one-hot tree victim directly.
  always_comb begin
    w_on    = '0;
    w_on[1] = 1'b1;
    for (int n = 1; n < WAYS; n++) begin
      w_on[2*n]   = w_on[n] & ~w_look_tree[n-1];
      w_on[2*n+1] = w_on[n] &  w_look_tree[n-1];
    end
  end

  // Access update: w_sub[n] is set when the accessed way sits below node n, which for a
  // one-hot way means n is on its path. Such a node points at the sibling half: 1 when the
  // access went to the lower child, 0 when it went to the upper one.
  always_comb begin
    w_sub = '0;
    w_sub[2*WAYS-1:WAYS] = bus.access_way;
    for (int n = WAYS - 1; n >= 1; n--) begin
      w_sub[n] = w_sub[2*n] | w_sub[2*n+1];
    end
    w_acc_next = w_acc_tree;
    for (int n = 1; n < WAYS; n++) begin
      if (w_sub[n]) begin
        w_acc_next[n-1] = w_sub[2*n];
      end
    end
  end

  // Invalid-first: the last hit of an ascending scan is the highest-index invalid way.
  always_comb begin
    w_inv_sel = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!bus.valid[i]) begin
        w_inv_sel    = '0;
        w_inv_sel[i] = 1'b1;
      end
    end
  end

  // The lookup result is taken from the tree before this edge's access/flush write, so an
  // access in the same cycle never changes the victim being returned.
  always_ff @(posedge clk_l1 or posedge rst_l1) begin
    if (rst_l1) begin
      r_tree <= '{default: '0};
      r_ack  <= 1'b0;
      r_way  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_ack <= bus.lookup_req;
      if (bus.lookup_req) begin
        r_way <= w_any_inv ? w_inv_sel : w_on[2*WAYS-1:WAYS];
      end
      // A flush drops any same-cycle access entirely, including its error report.
      r_err <= bus.access_en & ~bus.flush & ~w_acc_ok;
      if (bus.flush) begin
        r_tree <= '{default: '0};
      end else if (bus.access_en && w_acc_ok) begin
        r_tree[w_acc_idx] <= w_acc_next;
      end
    end
  end

  assign bus.lookup_ack  = r_ack;
  assign bus.replace_way = r_way;
  assign bus.err         = r_err;

endmodule
